// File: rtl/sdram_arb_pkg.sv
// Shared definitions for the two-port SDRAM controller arbiter.
package sdram_arb_pkg;

    localparam int unsigned SDRAM_ARB_AW = 16;
    localparam int unsigned SDRAM_ARB_DW = 32;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_REQ    = 2'd1,
        ST_RDWAIT = 2'd2
    } arb_state_t;

endpackage

// File: rtl/sdram_arb_pick.sv
// Winner selection between the two requesters.
// Build option: SDRAM_ARB_ROUND_ROBIN_EN (alternate on contention); default is fixed port-0 priority.
module sdram_arb_pick
    import sdram_arb_pkg::*;
(
    input  logic p0_req,
    input  logic p1_req,
    input  logic last,
    output logic win_c
);

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    // On contention the port that was not served last wins; a lone requester always wins.
    always_comb begin
        win_c = 1'b0;
        if (p0_req && p1_req) begin
            win_c = ~last;
        end else if (p1_req) begin
            win_c = 1'b1;
        end
    end
`else
    logic unused_last;

    assign unused_last = last;
    assign win_c       = ~p0_req & p1_req;
`endif

endmodule

// File: rtl/sdram_arbiter.sv
// Two-port arbiter in front of the SDRAM controller: one transaction outstanding,
// grant held until a write is acked or a read's valid returns. Option: SDRAM_ARB_ROUND_ROBIN_EN.
module sdram_arbiter
    import sdram_arb_pkg::*;
#(
    parameter int unsigned AW = SDRAM_ARB_AW,
    parameter int unsigned DW = SDRAM_ARB_DW
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          p0_req,
    input  logic          p0_we,
    input  logic [AW-1:0] p0_addr,
    input  logic [DW-1:0] p0_din,
    output logic          p0_ack,
    output logic          p0_valid,
    output logic [DW-1:0] p0_q,
    input  logic          p1_req,
    input  logic          p1_we,
    input  logic [AW-1:0] p1_addr,
    input  logic [DW-1:0] p1_din,
    output logic          p1_ack,
    output logic          p1_valid,
    output logic [DW-1:0] p1_q,
    output logic          mem_req,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_din,
    input  logic          mem_ack,
    input  logic          mem_valid,
    input  logic [DW-1:0] mem_q,
    output logic          grant,
    output logic          busy
);

    arb_state_t state;
    logic       last;
    logic       win_c;
    logic       ack_c;
    logic       fwd_valid_c;

    sdram_arb_pick u_pick (
        .p0_req (p0_req),
        .p1_req (p1_req),
        .last   (last),
        .win_c  (win_c)
    );

    // Request values are captured on the IDLE->REQ edge and held for the whole transaction.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= ST_IDLE;
            mem_req  <= 1'b0;
            mem_we   <= 1'b0;
            mem_addr <= '0;
            mem_din  <= '0;
            grant    <= 1'b0;
            last     <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (p0_req || p1_req) begin
                        grant    <= win_c;
                        last     <= win_c;
                        mem_req  <= 1'b1;
                        mem_we   <= win_c ? p1_we   : p0_we;
                        mem_addr <= win_c ? p1_addr : p0_addr;
                        mem_din  <= win_c ? p1_din  : p0_din;
                        state    <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (mem_ack) begin
                        mem_req <= 1'b0;
                        state   <= (mem_we || mem_valid) ? ST_IDLE : ST_RDWAIT;
                    end
                end
                ST_RDWAIT: begin
                    if (mem_valid) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    mem_req <= 1'b0;
                end
            endcase
        end
    end

    // Valid is forwarded only while a read is owed: in RDWAIT, or coincident with a read's ack.
    assign ack_c       = mem_ack & (state == ST_REQ);
    assign fwd_valid_c = mem_valid & ((state == ST_RDWAIT) | (ack_c & ~mem_we));

    assign p0_ack   = ack_c & ~grant;
    assign p1_ack   = ack_c &  grant;
    assign p0_valid = fwd_valid_c & ~grant;
    assign p1_valid = fwd_valid_c &  grant;
    assign p0_q     = mem_q;
    assign p1_q     = mem_q;
    assign busy     = (state != ST_IDLE);

endmodule

// File: tb/tb_sdram_arbiter.sv
// Randomized bench for sdram_arbiter against a transaction-level arbiter/memory model.
module tb_sdram_arbiter;

    localparam int unsigned AW = 16;
    localparam int unsigned DW = 32;

    typedef struct {
        logic          we;
        logic [AW-1:0] addr;
        logic [DW-1:0] din;
        int            dly;
    } txn_t;

    logic          clk;
    logic          reset;
    logic          p0_req, p0_we, p0_ack, p0_valid;
    logic [AW-1:0] p0_addr;
    logic [DW-1:0] p0_din, p0_q;
    logic          p1_req, p1_we, p1_ack, p1_valid;
    logic [AW-1:0] p1_addr;
    logic [DW-1:0] p1_din, p1_q;
    logic          mem_req, mem_we, mem_ack, mem_valid;
    logic [AW-1:0] mem_addr;
    logic [DW-1:0] mem_din, mem_q;
    logic          grant, busy;

    int errors = 0;
    int checks = 0;

    // requester state
    txn_t q0[$];
    txn_t q1[$];
    txn_t cur[2];
    bit   act[2], staged[2], acked[2], g[2];
    int   wcnt[2];

    // arbiter reference model
    bit   m_free, m_req, m_last, pend_ack, pend_done;
    int   m_owner;
    txn_t o;
    logic [DW-1:0] rmem[256];

    // controller model
    int            c_phase, c_cnt;
    logic [AW-1:0] c_addr;
    logic [DW-1:0] cmem[256];

    int  ack_lat_fix, val_lat_fix, spur_pct, gen_pct;
    bit  rand_gen;
    int  ack_seen[2], val_seen[2];
    logic [DW-1:0] last_q[2];
    int  grant_log[$];

    sdram_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .p0_req    (p0_req),
        .p0_we     (p0_we),
        .p0_addr   (p0_addr),
        .p0_din    (p0_din),
        .p0_ack    (p0_ack),
        .p0_valid  (p0_valid),
        .p0_q      (p0_q),
        .p1_req    (p1_req),
        .p1_we     (p1_we),
        .p1_addr   (p1_addr),
        .p1_din    (p1_din),
        .p1_ack    (p1_ack),
        .p1_valid  (p1_valid),
        .p1_q      (p1_q),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_din   (mem_din),
        .mem_ack   (mem_ack),
        .mem_valid (mem_valid),
        .mem_q     (mem_q),
        .grant     (grant),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0h want %0h at %0t", tag, got, want, $time);
        end
    endtask

    // Arbitration rule as stated: fixed port-0 priority, or on contention the port not served last.
    function automatic int pick(input bit r0, input bit r1, input bit last);
        if (r0 && r1) begin
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
            return last ? 0 : 1;
`else
            return 0;
`endif
        end
        return r0 ? 0 : 1;
    endfunction

    function automatic txn_t rand_txn();
        txn_t t;
        t.we   = 1'($urandom_range(0, 1));
        t.addr = AW'($urandom_range(0, 15));
        t.din  = $urandom;
        t.dly  = 0;
        return t;
    endfunction

    task automatic model_reset();
        m_free = 1; m_req = 0; m_last = 1; m_owner = 0;
        pend_ack = 0; pend_done = 0; c_phase = 0; c_cnt = 0;
        for (int p = 0; p < 2; p++) begin
            act[p] = 0; staged[p] = 0; acked[p] = 0; g[p] = 0; wcnt[p] = 0;
        end
        q0.delete();
        q1.delete();
    endtask

    task automatic clear_counts();
        for (int p = 0; p < 2; p++) begin
            ack_seen[p] = 0; val_seen[p] = 0; last_q[p] = '0;
        end
    endtask

    // Requesters show their command while waiting; once granted their fields are scrambled.
    task automatic drive_ports();
        p0_req = act[0];
        p1_req = act[1];
        if (act[0] && !g[0]) begin
            p0_we = cur[0].we; p0_addr = cur[0].addr; p0_din = cur[0].din;
        end else begin
            p0_we = 1'($urandom_range(0, 1)); p0_addr = AW'($urandom); p0_din = $urandom;
        end
        if (act[1] && !g[1]) begin
            p1_we = cur[1].we; p1_addr = cur[1].addr; p1_din = cur[1].din;
        end else begin
            p1_we = 1'($urandom_range(0, 1)); p1_addr = AW'($urandom); p1_din = $urandom;
        end
    endtask

    task automatic step();
        bit rq0, rq1, ack_d, val_d, e_ack, legit;
        int w;
        logic [DW-1:0] want_q;
        @(negedge clk);
        rq0 = p0_req;
        rq1 = p1_req;
        // effect of the posedge just past
        if (m_free && (rq0 || rq1)) begin
            w = pick(rq0, rq1, m_last);
            m_last = (w == 1); m_owner = w; o = cur[w]; g[w] = 1;
            m_free = 0; m_req = 1;
            grant_log.push_back(w);
        end else begin
            if (pend_ack)  m_req  = 0;
            if (pend_done) m_free = 1;
        end
        pend_ack = 0;
        pend_done = 0;

        check("mem_req", 64'(mem_req), 64'(m_req));
        check("busy", 64'(busy), 64'(!m_free));
        if (!m_free) check("grant", 64'(grant), 64'(m_owner));
        if (m_req) begin
            check("mem_addr", 64'(mem_addr), 64'(o.addr));
            check("mem_din", 64'(mem_din), 64'(o.din));
            check("mem_we", 64'(mem_we), 64'(o.we));
        end

        for (int p = 0; p < 2; p++) begin
            if (acked[p]) begin act[p] = 0; acked[p] = 0; end
            if (!act[p] && !staged[p]) begin
                if (p == 0 && q0.size() > 0) begin
                    cur[0] = q0.pop_front(); staged[0] = 1; wcnt[0] = cur[0].dly;
                end else if (p == 1 && q1.size() > 0) begin
                    cur[1] = q1.pop_front(); staged[1] = 1; wcnt[1] = cur[1].dly;
                end else if (rand_gen && int'($urandom_range(0, 99)) < gen_pct) begin
                    cur[p] = rand_txn(); staged[p] = 1; wcnt[p] = 0;
                end
            end
            if (staged[p]) begin
                if (wcnt[p] == 0) begin
                    act[p] = 1; staged[p] = 0; g[p] = 0;
                end else begin
                    wcnt[p]--;
                end
            end
        end
        drive_ports();

        // controller: ack after a latency, read data after a further latency
        ack_d = 0;
        val_d = 0;
        mem_q = $urandom;
        if (c_phase == 0 && mem_req) begin
            c_phase = 1;
            c_cnt = (ack_lat_fix >= 0) ? ack_lat_fix : int'($urandom_range(0, 3));
        end
        if (c_phase == 1) begin
            if (c_cnt == 0) begin
                ack_d = 1;
                c_addr = mem_addr;
                if (mem_we) begin
                    cmem[mem_addr[7:0]] = mem_din;
                    c_phase = 0;
                end else begin
                    c_cnt = (val_lat_fix >= 0) ? val_lat_fix : int'($urandom_range(0, 5));
                    if (c_cnt == 0) begin
                        val_d = 1; mem_q = cmem[c_addr[7:0]]; c_phase = 0;
                    end else begin
                        c_phase = 2;
                    end
                end
            end else begin
                c_cnt--;
            end
        end else if (c_phase == 2) begin
            c_cnt--;
            if (c_cnt == 0) begin
                val_d = 1; mem_q = cmem[c_addr[7:0]]; c_phase = 0;
            end
        end
        if (!val_d && c_phase == 0 && (!mem_req || (ack_d && mem_we)) &&
            int'($urandom_range(0, 99)) < spur_pct) begin
            val_d = 1;
        end
        mem_ack = ack_d;
        mem_valid = val_d;

        e_ack = ack_d && m_req;
        legit = val_d && !m_free && !o.we && (e_ack || !m_req);
        if (e_ack) begin
            pend_ack = 1;
            acked[m_owner] = 1;
            if (o.we) begin
                rmem[o.addr[7:0]] = o.din;
                pend_done = 1;
            end
        end
        if (legit) pend_done = 1;
        want_q = rmem[o.addr[7:0]];

        #1;
        check("p0_ack", 64'(p0_ack), 64'(e_ack && m_owner == 0));
        check("p1_ack", 64'(p1_ack), 64'(e_ack && m_owner == 1));
        check("p0_valid", 64'(p0_valid), 64'(legit && m_owner == 0));
        check("p1_valid", 64'(p1_valid), 64'(legit && m_owner == 1));
        if (legit) check("rd_q", 64'((m_owner == 0) ? p0_q : p1_q), 64'(want_q));
        ack_seen[0] += int'(p0_ack);
        ack_seen[1] += int'(p1_ack);
        val_seen[0] += int'(p0_valid);
        val_seen[1] += int'(p1_valid);
        if (p0_valid) last_q[0] = p0_q;
        if (p1_valid) last_q[1] = p1_q;
    endtask

    task automatic drain(input string tag);
        int n = 0;
        while ((!m_free || act[0] || act[1] || staged[0] || staged[1] ||
                q0.size() > 0 || q1.size() > 0 || pend_done) && n < 400) begin
            step();
            n++;
        end
        check({tag, "_timeout"}, 64'(n < 400), 64'(1));
        step();
        step();
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        mem_ack = 1'b1;
        mem_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        mem_valid = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        reset = 1'b0;
        model_reset();
    endtask

    initial begin
        int exp_g[4];
        int n;
        for (int i = 0; i < 256; i++) begin
            cmem[i] = 32'h1000_0000 + 32'(i);
            rmem[i] = 32'h1000_0000 + 32'(i);
        end
        ack_lat_fix = -1; val_lat_fix = -1; spur_pct = 0; gen_pct = 0; rand_gen = 0;
        clear_counts();
        model_reset();
        p0_req = 0; p0_we = 0; p0_addr = '0; p0_din = '0;
        p1_req = 0; p1_we = 0; p1_addr = '0; p1_din = '0;
        mem_ack = 1; mem_valid = 1; mem_q = '0;

        // reset values, with controller strobes active
        reset = 1'b1;
        p0_req = 1; p1_req = 1;
        #12;
        check("rst_mem_req", 64'(mem_req), 64'(0));
        check("rst_mem_we", 64'(mem_we), 64'(0));
        check("rst_mem_addr", 64'(mem_addr), 64'(0));
        check("rst_mem_din", 64'(mem_din), 64'(0));
        check("rst_grant", 64'(grant), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_p0_ack", 64'(p0_ack), 64'(0));
        check("rst_p1_ack", 64'(p1_ack), 64'(0));
        check("rst_p0_valid", 64'(p0_valid), 64'(0));
        check("rst_p1_valid", 64'(p1_valid), 64'(0));
        apply_reset();

        // simultaneous writes, both ports kept requesting
        ack_lat_fix = 1;
        grant_log.delete();
        q0.push_back('{1'b1, 16'h0020, 32'hA0A0_0001, 0});
        q0.push_back('{1'b1, 16'h0021, 32'hA0A0_0002, 0});
        q1.push_back('{1'b1, 16'h0022, 32'hB0B0_0001, 0});
        q1.push_back('{1'b1, 16'h0023, 32'hB0B0_0002, 0});
        drain("sim");
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 1, 1};
`endif
        check("sim_grants", 64'(grant_log.size()), 64'(4));
        for (int i = 0; i < 4 && i < grant_log.size(); i++) begin
            check("sim_grant_order", 64'(grant_log[i]), 64'(exp_g[i]));
        end

        // port 0 write then read back
        ack_lat_fix = 3; val_lat_fix = 5;
        clear_counts();
        q0.push_back('{1'b1, 16'h0012, 32'hFFED_0012, 0});
        drain("wr");
        check("wr_p0_acks", 64'(ack_seen[0]), 64'(1));
        check("wr_p1_acks", 64'(ack_seen[1]), 64'(0));
        q0.push_back('{1'b0, 16'h0012, 32'h0, 0});
        drain("rd");
        check("rd_p0_valids", 64'(val_seen[0]), 64'(1));
        check("rd_p1_valids", 64'(val_seen[1]), 64'(0));
        check("rd_p0_q", 64'(last_q[0]), 64'(32'hFFED_0012));

        // read hold-off: p1 arrives while p0's read is outstanding
        ack_lat_fix = 1; val_lat_fix = 5;
        grant_log.delete();
        q0.push_back('{1'b0, 16'h0003, 32'h0, 0});
        q1.push_back('{1'b1, 16'h0004, 32'hC0DE_0004, 2});
        drain("hold");
        check("hold_n", 64'(grant_log.size()), 64'(2));
        if (grant_log.size() == 2) begin
            check("hold_first", 64'(grant_log[0]), 64'(0));
            check("hold_second", 64'(grant_log[1]), 64'(1));
        end

        // ack and valid in the same cycle, then a normal request
        val_lat_fix = 0;
        clear_counts();
        q1.push_back('{1'b0, 16'h0012, 32'h0, 0});
        q0.push_back('{1'b1, 16'h0005, 32'h5555_AAAA, 1});
        drain("same");
        check("same_p1_valid", 64'(val_seen[1]), 64'(1));
        check("same_p1_ack", 64'(ack_seen[1]), 64'(1));
        check("same_p0_ack", 64'(ack_seen[0]), 64'(1));
        check("same_p1_q", 64'(last_q[1]), 64'(32'hFFED_0012));

        // spurious valid while idle
        clear_counts();
        spur_pct = 100;
        for (int i = 0; i < 6; i++) step();
        spur_pct = 0;
        check("spur_valids", 64'(val_seen[0] + val_seen[1]), 64'(0));

        // reset in the middle of a request
        ack_lat_fix = 6; val_lat_fix = -1;
        q0.push_back('{1'b1, 16'h0033, 32'h1234_5678, 0});
        n = 0;
        while (mem_req !== 1'b1 && n < 20) begin
            step();
            n++;
        end
        check("mid_reached_req", 64'(mem_req), 64'(1));
        reset = 1'b1;
        #1;
        mem_ack = 1'b1;
        mem_valid = 1'b1;
        #1;
        check("mid_mem_req", 64'(mem_req), 64'(0));
        check("mid_busy", 64'(busy), 64'(0));
        check("mid_p0_ack", 64'(p0_ack), 64'(0));
        check("mid_p1_ack", 64'(p1_ack), 64'(0));
        check("mid_p0_valid", 64'(p0_valid), 64'(0));
        @(posedge clk);
        @(negedge clk);
        mem_ack = 1'b0;
        mem_valid = 1'b0;
        p0_req = 1'b0;
        p1_req = 1'b0;
        reset = 1'b0;
        model_reset();
        ack_lat_fix = -1;
        q1.push_back('{1'b1, 16'h0034, 32'h8765_4321, 0});
        n = 0;
        while (mem_req !== 1'b1 && n < 10) begin
            step();
            n++;
        end
        check("post_rst_latency", 64'(n <= 2), 64'(1));
        check("post_rst_grant", 64'(grant), 64'(1));
        drain("post_rst");

        // randomized traffic
        rand_gen = 1; gen_pct = 35; spur_pct = 10;
        ack_lat_fix = -1; val_lat_fix = -1;
        for (int i = 0; i < 3000; i++) step();
        rand_gen = 0; spur_pct = 0;
        drain("rand");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sdram_arbiter.md
Name: sdram_arbiter

Overview:
- Two-port arbiter that shares the single SDRAM controller (req/ack/valid protocol, 16-bit word address, 32-bit data) between two requesters, e.g. CPU (port 0) and video/DMA (port 1).
- Sits between the requesters and the controller's system interface, in the clk_sdram domain.
- Allows one transaction outstanding at a time; the grant is held until a write is acked or a read's valid returns.

Parameters:
- AW, 16, word address width.
- DW, 32, data width.

Ports:
- clk  in  1  controller clock.
- reset  in  1  asynchronous, active-high reset.
- p0_req  in  1  port 0 request; held until p0_ack.
- p0_we  in  1  port 0 write enable, 1 = write.
- p0_addr  in  AW  port 0 word address.
- p0_din  in  DW  port 0 write data.
- p0_ack  out  1  port 0 request accepted, 1-cycle pulse.
- p0_valid  out  1  port 0 read data valid, 1-cycle pulse.
- p0_q  out  DW  port 0 read data.
- p1_req, p1_we, p1_addr, p1_din, p1_ack, p1_valid, p1_q: same as port 0, for port 1.
- mem_req  out  1  to controller req.
- mem_we  out  1  to controller we.
- mem_addr  out  AW  to controller addr.
- mem_din  out  DW  to controller data.
- mem_ack  in  1  from controller ack.
- mem_valid  in  1  from controller valid.
- mem_q  in  DW  from controller q.
- grant  out  1  index of the port currently owning the controller.
- busy  out  1  high in any state other than IDLE.

Behaviour:
- Reset (asynchronous, level): state=IDLE, mem_req=0, mem_we=0, mem_addr=0, mem_din=0, grant=0, last=1.
- During reset, all pN_ack/pN_valid outputs are 0.
- Reset mid-transaction abandons the transaction with no ack or valid delivered. The controller shares the same reset.
- States: IDLE, REQ, RDWAIT.
- IDLE:
  - If any pN_req, pick a winner and register grant, mem_addr, mem_din and mem_we from the winner's port, set mem_req=1, go to REQ.
  - mem_req therefore rises 1 cycle after the requester's req is first sampled.
  - With no request, stay in IDLE.
- REQ:
  - mem_req held at 1; mem_addr, mem_din and mem_we are stable.
  - On mem_ack, set mem_req=0.
  - If mem_we=1, go to IDLE. If mem_we=0, go to RDWAIT.
  - If mem_valid arrives in the same cycle as mem_ack on a read, deliver it and go to IDLE.
- RDWAIT: on mem_valid, go to IDLE. There is no timeout.
- pN_ack is combinational: mem_ack & (state==REQ) & (grant==N). This lets a requester that clears its req on the ack edge be deasserted by the next IDLE cycle, so there is no double issue.
- pN_valid is combinational: mem_valid & (state==RDWAIT, or the REQ read-ack case) & (grant==N).
- pN_q = mem_q, broadcast to both ports; it is meaningful only when qualified by pN_valid.
- mem_valid in IDLE, or in REQ for a write, is ignored; no valid is forwarded.
- Back-to-back:
  - A write completes in IDLE→REQ→(ack)→IDLE, so the minimum spacing is 2 cycles plus the controller's ack latency.
  - A new arbitration always takes one IDLE cycle.
- Fixed-priority arbitration (macro undefined): port 0 wins whenever p0_req=1. Port 1 can starve; this is accepted.
- `last` records the most recently granted port. It is updated on every grant and used only by the optional feature.
- A requester changing addr/din/we while waiting has no effect after the grant; values are captured on the IDLE→REQ edge.

Optional Feature:
- Macro SDRAM_ARB_ROUND_ROBIN_EN.
- When defined: if both ports request in IDLE, the port != last wins. A single requester always wins.
- When undefined: fixed priority, port 0 first. `last` is still maintained but unused.

Decomposition:
- Package sdram_arb_pkg holds:
  - state encoding constants ST_IDLE=2'd0, ST_REQ=2'd1, ST_RDWAIT=2'd2;
  - default AW=16 and DW=32.
- One natural sub-module, sdram_arb_pick: combinational winner selection from (p0_req, p1_req, last), containing the ifdef.
- The FSM and capture registers stay in the top module.

Test Plan:
- Write then read, port 0:
  - p0 writes addr=0x0012, din=0xFFED0012; a controller model acks 3 cycles later → one p0_ack pulse, mem_addr=0x0012, mem_we=1, FSM back to IDLE.
  - p0 then reads 0x0012; valid returns 5 cycles after ack → p0_valid=1 for one cycle with p0_q=0xFFED0012, and p1_valid stays 0.
- Simultaneous requests: p0 and p1 both request writes in the same cycle.
  - Fixed priority: p0 is served first, then p1; grant goes 0 then 1.
  - With SDRAM_ARB_ROUND_ROBIN_EN after reset (last=1): p0 first. With both held continuously, grants alternate 0,1,0,1 over 4 transactions.
- Read hold-off: p0 read outstanding (RDWAIT) while p1 requests → mem_req stays 0 and p1_ack stays 0 until p0_valid. p1 is granted on the next IDLE cycle.
- Same-cycle ack and valid on a read → pN_valid and pN_ack both 1 in that cycle; FSM goes to IDLE; the next request is accepted normally.
- Reset mid-transaction: assert reset in REQ → mem_req=0, busy=0 immediately without waiting for a clock edge; no pN_ack is produced. After release, a new p1 request is granted within 2 cycles.
- Spurious mem_valid in IDLE → p0_valid=0 and p1_valid=0; state unchanged.
